neuron_mac_seq: RTL and testbench
=================================

# neuron_mac_seq

Parametrised sequential neuron for the AI-accelerator datapath. It has N_IN runtime-loadable signed Q-format weights and a bias. It accepts one input sample per cycle over a valid/ready stream and accumulates the weighted sum in a single multiply-accumulate unit. After the last input it applies a selectable activation (linear or ReLU) with saturation, then presents one signed result on a valid/ready output stream. It supersedes the fixed two-input combinational neuron and is the building block for multi-neuron layers.

## Interface
- N_IN, 4: inputs per neuron (≥2).
- DATA_W, 16: width of inputs, weights, bias and output (signed, two's complement).
- FRAC_W, 8: fractional bits of the fixed-point format for all operands.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous and active-high.
- w_we  in  1  weight write strobe.
- w_addr  in  clog2(N_IN)  weight index.
- w_data  in  DATA_W  weight value.
- b_we  in  1  bias write strobe.
- b_data  in  DATA_W  bias value.
- act_relu  in  1  1 = ReLU, 0 = linear; sampled with the first input of each vector.
- x_valid  in  1  input sample valid.
- x_ready  out  1  block can accept a sample.
- x_data  in  DATA_W  input sample, in index order 0..N_IN-1.
- y_valid  out  1  result valid.
- y_ready  in  1  downstream accepts the result.
- y_data  out  DATA_W  activated, saturated result.
- y_sat  out  1  result was clipped; qualified by y_valid.
- cfg_err  out  1  one-cycle pulse when a weight or bias write is dropped.

## Operation
- States:
  - IDLE: x_ready=1, acc cleared.
  - ACCUM: x_ready=1.
  - FINISH: x_ready=0.
  - OUT: x_ready=0, y_valid=1.
- A transfer occurs when x_valid && x_ready.
- The first transfer goes IDLE→ACCUM:
  - acc ← x·w[0];
  - act_relu is latched;
  - idx ← 1.
- Each later transfer does acc ← acc + x·w[idx] and idx++.
- The transfer with idx = N_IN-1 moves the FSM to FINISH.
- FINISH computes the result and moves to OUT in one cycle:
  - s = (acc + (bias <<< FRAC_W)) >>> FRAC_W, an arithmetic shift (rounding toward −∞);
  - s is saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1], and y_sat is set if clipping occurred;
  - if ReLU is latched and s < 0, the result is 0 with y_sat=0.
- In OUT, y_valid && y_ready moves the FSM to IDLE. The next vector can be accepted in the cycle after the handoff.
- Arithmetic widths:
  - product is 2·DATA_W bits;
  - ACC_W = 2·DATA_W + clog2(N_IN) + 1, so the accumulator never wraps.
- Weight and bias writes take effect only in IDLE. Writes in any other state are dropped and cfg_err pulses the next cycle.
- A simultaneous w_we and b_we in IDLE performs both writes.
- A write in the same IDLE cycle as the first x transfer is dropped (cfg_err pulses), so every vector uses a stable weight set.
- Reset values:
  - weights and bias = 0;
  - FSM = IDLE, idx = 0, acc = 0;
  - x_ready = 0 during reset and 1 in the first cycle after release;
  - y_valid = 0, y_data = 0, y_sat = 0, cfg_err = 0.
- Reset asserted mid-vector discards the partial sum and any pending output.

## Timing
- Throughput: one input per cycle with no bubbles inside a vector.
- Latency: the last input is transferred at edge t; FINISH runs during cycle t+1; y_valid rises after edge t+1.
- Back-to-back vector period: N_IN + 2 cycles when y_ready is held high.
- While y_ready=0, y_data and y_sat stay stable and x_ready stays 0.
- x_ready does not depend combinationally on x_valid; y_valid does not depend combinationally on y_ready.
- Weight and bias writes are visible from the next cycle.

## Structure
- Package neuron_pkg:
  - state enum {IDLE, ACCUM, FINISH, OUT};
  - a function computing ACC_W;
  - a saturate/shift function parameterised on the widths.
- Sub-module neuron_mac_unit: a signed multiplier plus accumulator with clear/load/accumulate controls, reused by later layer blocks.
- The top level holds the weight register file, the FSM and the activation/saturation stage.

## Test plan
- Basic sum: N_IN=2, w = {256, 256} (1.0 each), bias = 0, linear, x = {1000, 2000} → y_data = 3000, y_sat = 0, y_valid two cycles after the last input.
- Bias and ReLU: N_IN=4, w = 256 each, bias = −5000:
  - x = {1000, 1000, 1000, 1000} with ReLU → y = 0;
  - same inputs, linear → y = −1000.
- Saturation: w = 0x7FFF each, x = 0x7FFF each → y = 32767, y_sat = 1. With all inputs 0x8000 and w = 0x7FFF → y = −32768, y_sat = 1.
- Backpressure: hold y_ready = 0 for 5 cycles → y_data stable, x_ready = 0, no input transferred. Vector period is N_IN + 2 with y_ready held high.
- Config hazard: a w_we during ACCUM → cfg_err pulses once and the result matches the old weights. The same write in IDLE takes effect on the next vector.
- Reset mid-vector: assert rst after 2 of 4 inputs → outputs take their reset values. A fresh vector then yields the correct sum with no residue from the aborted one.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and arithmetic helpers for the sequential neuron and the
// layer blocks built from it.
package neuron_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUT} state_e;

    // Wide enough for any accumulator plus shifted bias this family uses.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] val;
        logic                    sat;
    } sat_t;

    function automatic int acc_width(input int data_w, input int n_in);
        return 2 * data_w + $clog2(n_in) + 1;
    endfunction

    // Arithmetic right shift (floor) followed by clipping to a signed out_w range.
    function automatic sat_t shift_sat(input logic signed [SAT_W-1:0] v,
                                       input int frac_w, input int out_w);
        sat_t r;
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        s  = v >>> frac_w;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        r.sat = 1'b1;
        if (s > hi) begin
            r.val = hi;
        end else if (s < lo) begin
            r.val = lo;
        end else begin
            r.val = s;
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_mac_unit.sv
// Signed multiply-accumulate: clear, load with a fresh product, or add the
// product onto the running sum.
module neuron_mac_unit
    import neuron_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 35
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              acc_en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;

    assign prod     = $signed(a_i) * $signed(b_i);
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign acc_o    = acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (load_i) begin
            acc_q <= prod_ext;
        end else if (acc_en_i) begin
            acc_q <= acc_q + prod_ext;
        end
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential neuron: streams N_IN samples through one MAC, adds bias, then
// applies linear/ReLU activation with saturation on a valid/ready output.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_we,
    input  logic [$clog2(N_IN)-1:0]   w_addr,
    input  logic [DATA_W-1:0]         w_data,
    input  logic                      b_we,
    input  logic [DATA_W-1:0]         b_data,
    input  logic                      act_relu,
    input  logic                      x_valid,
    output logic                      x_ready,
    input  logic [DATA_W-1:0]         x_data,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic [DATA_W-1:0]         y_data,
    output logic                      y_sat,
    output logic                      cfg_err
);

    localparam int IDX_W = $clog2(N_IN);
    localparam int ACC_W = acc_width(DATA_W, N_IN);

    logic [DATA_W-1:0] w_q [N_IN];
    logic [DATA_W-1:0] bias_q;

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              relu_q;
    logic              y_valid_q;
    logic [DATA_W-1:0] y_data_q;
    logic              y_sat_q;
    logic              cfg_err_q;

    logic                    xfer;
    logic                    cfg_ok;
    logic [ACC_W-1:0]        acc;
    logic signed [SAT_W-1:0] acc_ext;
    logic signed [SAT_W-1:0] bias_ext;
    sat_t                    fin;

    assign x_ready = !rst && (state_q == IDLE || state_q == ACCUM);
    assign xfer    = x_valid && x_ready;
    // Config is frozen from the first sample on so a vector sees one weight set.
    assign cfg_ok  = (state_q == IDLE) && !xfer;

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_sat   = y_sat_q;
    assign cfg_err = cfg_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
            bias_q <= '0;
        end else if (cfg_ok) begin
            if (w_we) w_q[w_addr] <= w_data;
            if (b_we) bias_q <= b_data;
        end
    end

    neuron_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == IDLE && !xfer),
        .load_i   (xfer && state_q == IDLE),
        .acc_en_i (xfer && state_q == ACCUM),
        .a_i      (x_data),
        .b_i      (w_q[idx_q]),
        .acc_o    (acc)
    );

    assign acc_ext  = {{(SAT_W - ACC_W){acc[ACC_W-1]}}, acc};
    assign bias_ext = {{(SAT_W - DATA_W){bias_q[DATA_W-1]}}, bias_q} <<< FRAC_W;
    assign fin      = shift_sat(acc_ext + bias_ext, FRAC_W, DATA_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            relu_q    <= 1'b0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_sat_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (w_we || b_we) && !cfg_ok;
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        relu_q  <= act_relu;
                        idx_q   <= IDX_W'(1);
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        if (idx_q == IDX_W'(N_IN - 1)) begin
                            idx_q   <= '0;
                            state_q <= FINISH;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                FINISH: begin
                    // ReLU clamps negatives to zero, which is never a clip.
                    if (relu_q && ($signed(fin.val) < 0)) begin
                        y_data_q <= '0;
                        y_sat_q  <= 1'b0;
                    end else begin
                        y_data_q <= fin.val[DATA_W-1:0];
                        y_sat_q  <= fin.sat;
                    end
                    y_valid_q <= 1'b1;
                    state_q   <= OUT;
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: directed cases plus randomized vectors checked
// against a plain-arithmetic reference of the neuron's weighted sum.
module tb_neuron_mac_seq;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_we, b_we, act_relu, x_valid, x_ready, y_valid, y_ready, y_sat, cfg_err;
    logic [1:0]  w_addr;
    logic [15:0] w_data, b_data, x_data, y_data;

    logic        w_we2, b_we2, act_relu2, x_valid2, x_ready2, y_valid2, y_ready2, y_sat2, cfg_err2;
    logic [0:0]  w_addr2;
    logic [15:0] w_data2, b_data2, x_data2, y_data2;

    typedef struct {
        longint y;
        longint sat;
    } exp_t;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 cyc      = 0;
    int                 yr_mode  = 1;
    longint             m_w [N];
    longint             m_b;
    logic signed [15:0] cur_x [N];
    exp_t               q [$];
    longint             last_y   = 0;
    longint             last_sat = 0;

    neuron_mac_seq #(.N_IN(4), .DATA_W(16), .FRAC_W(8)) dut (
        .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_data(b_data), .act_relu(act_relu), .x_valid(x_valid),
        .x_ready(x_ready), .x_data(x_data), .y_valid(y_valid), .y_ready(y_ready),
        .y_data(y_data), .y_sat(y_sat), .cfg_err(cfg_err)
    );

    neuron_mac_seq #(.N_IN(2), .DATA_W(16), .FRAC_W(8)) dut2 (
        .clk(clk), .rst(rst), .w_we(w_we2), .w_addr(w_addr2), .w_data(w_data2),
        .b_we(b_we2), .b_data(b_data2), .act_relu(act_relu2), .x_valid(x_valid2),
        .x_ready(x_ready2), .x_data(x_data2), .y_valid(y_valid2), .y_ready(y_ready2),
        .y_data(y_data2), .y_sat(y_sat2), .cfg_err(cfg_err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur", name);
    endtask

    // Reference: exact integer sum, floor-divide by 2^8, clip, then ReLU.
    function automatic exp_t ref_model(input bit relu);
        exp_t   e;
        longint t, s;
        t = m_b * 256;
        for (int i = 0; i < N; i++) t += longint'(cur_x[i]) * m_w[i];
        s = (t - (((t % 256) + 256) % 256)) / 256;
        e.sat = 0;
        if (s > 32767) begin
            s = 32767; e.sat = 1;
        end else if (s < -32768) begin
            s = -32768; e.sat = 1;
        end
        if (relu && s < 0) begin
            s = 0; e.sat = 0;
        end
        e.y = s;
        return e;
    endfunction

    // Output checker: every cycle a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && y_valid) begin
            chk("x_ready_while_out", longint'(x_ready), 0);
            if (q.size() == 0) begin
                fail_now("expected_result_pending");
            end else begin
                chk("y_data", longint'($signed(y_data)), q[0].y);
                chk("y_sat", longint'(y_sat), q[0].sat);
                if (y_ready) begin
                    last_y   = longint'($signed(y_data));
                    last_sat = longint'(y_sat);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        y_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (yr_mode)
                0:       y_ready = 1'b0;
                1:       y_ready = 1'b1;
                default: y_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Call just after a clock edge while the DUT is idle.
    task automatic cfg_write(input bit dw, input int a, input logic [15:0] wv,
                             input bit db, input logic [15:0] bv);
        w_we = dw; w_addr = 2'(a); w_data = wv;
        b_we = db; b_data = bv;
        @(posedge clk);
        #1;
        w_we = 1'b0; b_we = 1'b0;
        chk("cfg_err_idle_write", longint'(cfg_err), 0);
        if (dw) m_w[a] = longint'($signed(wv));
        if (db) m_b = longint'($signed(bv));
    endtask

    task automatic set_all_w(input logic [15:0] wv, input logic [15:0] bv);
        for (int a = 0; a < N; a++) cfg_write(1'b1, a, wv, a == 0, bv);
    endtask

    task automatic send_vec(input bit relu, input int inj_k, input int inj_a,
                            input logic [15:0] inj_v, output int first_cyc);
        int n;
        first_cyc = 0;
        for (int i = 0; i < N; i++) begin
            x_valid  = 1'b1;
            x_data   = cur_x[i];
            act_relu = (i == 0) ? relu : !relu;
            if (i == inj_k) begin
                w_we = 1'b1; w_addr = 2'(inj_a); w_data = inj_v;
            end
            if (inj_k >= 0 && i == inj_k + 1) chk("cfg_err_pulse", longint'(cfg_err), 1);
            if (inj_k >= 0 && i == inj_k + 2) chk("cfg_err_single", longint'(cfg_err), 0);
            n = 0;
            @(negedge clk);
            while (!x_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!x_ready) fail_now("x_ready_timeout");
            @(posedge clk);
            #1;
            w_we = 1'b0;
            if (i == 0) first_cyc = cyc;
        end
        x_valid = 1'b0;
        q.push_back(ref_model(relu));
        chk("y_valid_low_in_finish", longint'(y_valid), 0);
        @(posedge clk);
        #1;
        chk("y_valid_latency", longint'(y_valid), 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (q.size() != 0 && n < 200);
        #1;
        if (q.size() != 0) fail_now("output_drain");
    endtask

    initial begin
        int fc1, fc2;
        rst = 1'b1;
        w_we = 0; b_we = 0; act_relu = 0; x_valid = 0; w_addr = 0; w_data = 0; b_data = 0; x_data = 0;
        w_we2 = 0; b_we2 = 0; act_relu2 = 0; x_valid2 = 0; y_ready2 = 1; w_addr2 = 0;
        w_data2 = 0; b_data2 = 0; x_data2 = 0;
        for (int i = 0; i < N; i++) m_w[i] = 0;
        m_b = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_x_ready", longint'(x_ready), 0);
        chk("reset_y_valid", longint'(y_valid), 0);
        chk("reset_y_data", longint'(y_data), 0);
        chk("reset_y_sat", longint'(y_sat), 0);
        chk("reset_cfg_err", longint'(cfg_err), 0);
        chk("reset_x_ready_n2", longint'(x_ready2), 0);
        rst = 1'b0;
        #1;
        chk("x_ready_after_release", longint'(x_ready), 1);
        @(posedge clk);
        #1;

        // Two-input neuron: 1000*1.0 + 2000*1.0
        w_we2 = 1; w_addr2 = 0; w_data2 = 16'd256;
        @(posedge clk); #1;
        w_addr2 = 1;
        @(posedge clk); #1;
        w_we2 = 0; x_valid2 = 1; x_data2 = 16'd1000;
        @(posedge clk); #1;
        x_data2 = 16'd2000;
        @(posedge clk); #1;
        x_valid2 = 0;
        chk("n2_y_valid_finish", longint'(y_valid2), 0);
        @(posedge clk); #1;
        chk("n2_y_valid", longint'(y_valid2), 1);
        chk("n2_y_data", longint'($signed(y_data2)), 3000);
        chk("n2_y_sat", longint'(y_sat2), 0);
        @(posedge clk); #1;
        chk("n2_y_valid_after_handoff", longint'(y_valid2), 0);

        // Bias and ReLU
        set_all_w(16'd256, 16'(-5000));
        for (int i = 0; i < N; i++) cur_x[i] = 16'sd1000;
        send_vec(1'b1, -1, 0, 16'd0, fc1);
        wait_drain();
        chk("relu_y", last_y, 0);
        chk("relu_sat", last_sat, 0);
        send_vec(1'b0, -1, 0, 16'd0, fc1);
        wait_drain();
        chk("linear_y", last_y, -1000);

        // Saturation in both directions
        set_all_w(16'h7FFF, 16'd0);
        for (int i = 0; i < N; i++) cur_x[i] = 16'sh7FFF;
        send_vec(1'b0, -1, 0, 16'd0, fc1);
        wait_drain();
        chk("sat_pos_y", last_y, 32767);
        chk("sat_pos_flag", last_sat, 1);
        for (int i = 0; i < N; i++) cur_x[i] = 16'sh8000;
        send_vec(1'b0, -1, 0, 16'd0, fc1);
        wait_drain();
        chk("sat_neg_y", last_y, -32768);
        chk("sat_neg_flag", last_sat, 1);

        // Backpressure: result held, no input accepted
        set_all_w(16'd256, 16'd0);
        cur_x[0] = 16'sd100; cur_x[1] = -16'sd200; cur_x[2] = 16'sd300; cur_x[3] = 16'sd400;
        yr_mode = 0;
        @(posedge clk); #2;
        send_vec(1'b0, -1, 0, 16'd0, fc1);
        repeat (5) begin
            x_valid = 1'b1;
            x_data  = 16'($urandom);
            @(negedge clk);
            chk("stall_x_ready", longint'(x_ready), 0);
            chk("stall_y_data", longint'($signed(y_data)), 600);
            @(posedge clk); #1;
        end
        x_valid = 1'b0;
        yr_mode = 1;
        wait_drain();
        chk("backpressure_y", last_y, 600);

        // Back-to-back vector period
        send_vec(1'b0, -1, 0, 16'd0, fc1);
        cur_x[0] = 16'sd7; cur_x[1] = 16'sd11; cur_x[2] = -16'sd13; cur_x[3] = 16'sd17;
        send_vec(1'b0, -1, 0, 16'd0, fc2);
        chk("vector_period", longint'(fc2 - fc1), N + 2);
        wait_drain();
        chk("period_second_y", last_y, 22);

        // Writes during a vector are dropped; in IDLE they apply to the next one
        for (int i = 0; i < N; i++) cur_x[i] = 16'sd1000;
        send_vec(1'b0, 1, 2, 16'd512, fc1);
        wait_drain();
        chk("hazard_old_weights", last_y, 4000);
        cfg_write(1'b1, 2, 16'd512, 1'b0, 16'd0);
        send_vec(1'b0, -1, 0, 16'd0, fc1);
        wait_drain();
        chk("hazard_new_weights", last_y, 5000);
        send_vec(1'b0, 0, 3, 16'd0, fc1);
        wait_drain();
        chk("write_with_first_sample", last_y, 5000);

        // Reset after two of four inputs
        x_valid = 1'b1; x_data = 16'd1000;
        @(posedge clk); #1;
        x_data = 16'd2000;
        @(posedge clk); #1;
        x_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < N; i++) m_w[i] = 0;
        m_b = 0;
        #1;
        chk("abort_x_ready", longint'(x_ready), 0);
        chk("abort_y_valid", longint'(y_valid), 0);
        chk("abort_y_data", longint'(y_data), 0);
        chk("abort_cfg_err", longint'(cfg_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_x_ready_release", longint'(x_ready), 1);
        cur_x[0] = 16'sd100; cur_x[1] = 16'sd200; cur_x[2] = 16'sd300; cur_x[3] = 16'sd400;
        send_vec(1'b0, -1, 0, 16'd0, fc1);
        wait_drain();
        chk("weights_cleared_by_reset", last_y, 0);
        set_all_w(16'd256, 16'd0);
        send_vec(1'b0, -1, 0, 16'd0, fc1);
        wait_drain();
        chk("fresh_vector_after_abort", last_y, 1000);

        // Randomized vectors with random output backpressure
        yr_mode = 2;
        for (int v = 0; v < 40; v++) begin
            if (v % 5 == 0) begin
                wait_drain();
                for (int a = 0; a < N; a++) begin
                    if (v % 10 == 0)
                        cfg_write(1'b1, a, 16'($urandom), a == 0, 16'($urandom));
                    else
                        cfg_write(1'b1, a, 16'($urandom_range(0, 1024) - 512), a == 1,
                                  16'($urandom_range(0, 4000) - 2000));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (v % 3 == 0) cur_x[i] = 16'($urandom);
                else            cur_x[i] = 16'($urandom_range(0, 8000) - 4000);
            end
            send_vec(1'($urandom_range(0, 1)), -1, 0, 16'd0, fc1);
        end
        yr_mode = 1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
